// File: rtl/spi_shift_engine.sv
// SPI master shift engine: pops words from the TX Fifo, serializes them on MOSI/SCLK
// and pushes the word assembled from MISO into the RX Fifo.
module spi_shift_engine #(
    parameter int unsigned DATA_BUS_SIZE   = 32,
    parameter int unsigned CLOCK_DIV_WIDTH = 8
) (
    input  logic                       clock,
    input  logic                       areset,
    input  logic                       enable,
    input  logic [CLOCK_DIV_WIDTH-1:0] clockDivider,
    input  logic                       cpol,
    input  logic                       cpha,
    input  logic                       lsbFirst,
    input  logic                       txEmpty,
    input  logic [DATA_BUS_SIZE-1:0]   txData,
    output logic                       txPop,
    input  logic                       rxFull,
    output logic                       rxPush,
    output logic [DATA_BUS_SIZE-1:0]   rxData,
    output logic                       sclk,
    output logic                       mosi,
    input  logic                       miso,
    output logic                       chipSelectN,
    output logic                       busy
);

    localparam int unsigned EdgeW = $clog2(2 * DATA_BUS_SIZE) + 1;
    localparam logic [EdgeW-1:0] LastEdge = EdgeW'(2 * DATA_BUS_SIZE - 1);

    typedef enum logic [1:0] {StIdle, StLead, StShift, StTrail} state_e;

    state_e                     state_q, state_d;
    logic [CLOCK_DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
    logic [CLOCK_DIV_WIDTH-1:0] div_q, div_d;
    logic [EdgeW-1:0]           edge_cnt_q, edge_cnt_d;
    logic [DATA_BUS_SIZE-1:0]   tx_q, tx_d;
    logic [DATA_BUS_SIZE-1:0]   rx_q, rx_d;
    logic [DATA_BUS_SIZE-1:0]   rx_data_q, rx_data_d;
    logic                       cpol_q, cpol_d;
    logic                       cpha_q, cpha_d;
    logic                       lsb_q, lsb_d;
    logic                       sclk_q, sclk_d;
    logic                       mosi_q, mosi_d;
    logic                       cs_n_q, cs_n_d;
    logic                       push_q, push_d;
    logic                       idle_ok_q, idle_ok_d;
    logic                       start, tick, load;

    always_ff @(posedge clock or negedge areset) begin
        if (!areset) begin
            state_q    <= StIdle;
            div_cnt_q  <= '0;
            div_q      <= '0;
            edge_cnt_q <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            rx_data_q  <= '0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            lsb_q      <= 1'b0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            push_q     <= 1'b0;
            idle_ok_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            div_q      <= div_d;
            edge_cnt_q <= edge_cnt_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            rx_data_q  <= rx_data_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            lsb_q      <= lsb_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            cs_n_q     <= cs_n_d;
            push_q     <= push_d;
            idle_ok_q  <= idle_ok_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        div_d      = div_q;
        edge_cnt_d = edge_cnt_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        rx_data_d  = rx_data_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        lsb_d      = lsb_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        cs_n_d     = cs_n_q;
        push_d     = 1'b0;
        idle_ok_d  = idle_ok_q;
        load       = 1'b0;
        start      = enable && !txEmpty && !rxFull;
        tick       = (div_cnt_q == div_q);

        unique case (state_q)
            StIdle: begin
                sclk_d = cpol;
                cs_n_d = 1'b1;
                // CS must stay high for a full half-period before the next frame.
                if (!idle_ok_q) begin
                    if (tick) begin
                        idle_ok_d = 1'b1;
                        div_cnt_d = '0;
                    end else begin
                        div_cnt_d = div_cnt_q + 1'b1;
                    end
                end else if (start) begin
                    load    = 1'b1;
                    state_d = StLead;
                end
            end
            StLead: begin
                if (tick) begin
                    div_cnt_d = '0;
                    state_d   = StShift;
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            StShift: begin
                if (tick) begin
                    div_cnt_d  = '0;
                    sclk_d     = !sclk_q;
                    edge_cnt_d = edge_cnt_q + 1'b1;
                    // Even count = leading edge; cpha selects which edge type samples.
                    if (edge_cnt_q[0] == cpha_q) begin
                        rx_d = lsb_q ? {miso, rx_q[DATA_BUS_SIZE-1:1]}
                                     : {rx_q[DATA_BUS_SIZE-2:0], miso};
                    end else begin
                        mosi_d = lsb_q ? tx_q[0] : tx_q[DATA_BUS_SIZE-1];
                        tx_d   = lsb_q ? (tx_q >> 1) : (tx_q << 1);
                    end
                    if (edge_cnt_q == LastEdge) begin
                        state_d   = StTrail;
                        push_d    = 1'b1;
                        rx_data_d = rx_d;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            StTrail: begin
                sclk_d = cpol_q;
                // The push cycle is extra, so pop (last cycle) never meets push (first).
                if (!push_q) begin
                    if (tick) begin
                        div_cnt_d = '0;
                        if (start) begin
                            load    = 1'b1;
                            state_d = StLead;
                        end else begin
                            state_d   = StIdle;
                            cs_n_d    = 1'b1;
                            idle_ok_d = 1'b0;
                        end
                    end else begin
                        div_cnt_d = div_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (load) begin
            cs_n_d     = 1'b0;
            cpol_d     = cpol;
            cpha_d     = cpha;
            lsb_d      = lsbFirst;
            div_d      = clockDivider;
            div_cnt_d  = '0;
            edge_cnt_d = '0;
            rx_d       = '0;
            sclk_d     = cpol;
            if (!cpha) begin
                mosi_d = lsbFirst ? txData[0] : txData[DATA_BUS_SIZE-1];
                tx_d   = lsbFirst ? (txData >> 1) : (txData << 1);
            end else begin
                tx_d = txData;
            end
        end
    end

    assign txPop       = load;
    assign rxPush      = push_q;
    assign rxData      = rx_data_q;
    assign sclk        = sclk_q;
    assign mosi        = mosi_q;
    assign chipSelectN = cs_n_q;
    assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed bench for spi_shift_engine: TX Fifo model, MISO slave model and an RX
// scoreboard filled when words are queued and drained on every rxPush.
module tb_spi_shift_engine;

    logic        clock;
    logic        areset;
    logic        enable;
    logic [7:0]  clockDivider;
    logic        cpol, cpha, lsbFirst;
    logic        txEmpty;
    logic [31:0] txData;
    logic        txPop;
    logic        rxFull;
    logic        rxPush;
    logic [31:0] rxData;
    logic        sclk, mosi, miso, chipSelectN, busy;

    spi_shift_engine #(.DATA_BUS_SIZE(32), .CLOCK_DIV_WIDTH(8)) dut (
        .clock        (clock),
        .areset       (areset),
        .enable       (enable),
        .clockDivider (clockDivider),
        .cpol         (cpol),
        .cpha         (cpha),
        .lsbFirst     (lsbFirst),
        .txEmpty      (txEmpty),
        .txData       (txData),
        .txPop        (txPop),
        .rxFull       (rxFull),
        .rxPush       (rxPush),
        .rxData       (rxData),
        .sclk         (sclk),
        .mosi         (mosi),
        .miso         (miso),
        .chipSelectN  (chipSelectN),
        .busy         (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int passed = 0;
    int total  = 0;

    logic [31:0] txq[$];
    logic [31:0] exp_q[$];
    logic        pop_pend = 1'b0;

    // Observed-event statistics, cleared per test
    int pops, pushes, coinc, edges, cs_rises, hp_min, hp_max, last_tog, mosi_n;
    int busy_cs_bad = 0;
    int cyc_n = 0;
    logic [31:0] mosi_cap;
    logic sclk_prev = 1'b0;
    logic cs_prev = 1'b1;

    logic        loop;
    logic        miso_s = 1'b0;
    logic [31:0] slave_word = '0;
    int          sidx = 0;

    assign miso = loop ? mosi : miso_s;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    task automatic refresh_tx();
        txEmpty = (txq.size() == 0);
        txData  = txEmpty ? 32'h0 : txq[0];
    endtask

    task automatic queue_word(input logic [31:0] w, input logic [31:0] expect_rx);
        txq.push_back(w);
        exp_q.push_back(expect_rx);
        refresh_tx();
    endtask

    task automatic reset_stats();
        pops = 0; pushes = 0; coinc = 0; edges = 0; cs_rises = 0;
        hp_min = 1000000; hp_max = 0; last_tog = -1; mosi_n = 0; mosi_cap = '0;
    endtask

    function automatic logic [31:0] bitrev(input logic [31:0] w);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = w[31-i];
        return r;
    endfunction

    task automatic wait_pushes(input int n, input int budget);
        int k;
        k = 0;
        while (pushes < n && k < budget) begin
            cyc();
            k++;
        end
        chk("push_count", 32'(pushes), 32'(n));
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < budget) begin
            cyc();
            k++;
        end
        chk("idle_reached", 32'(busy), 32'd0);
    endtask

    task automatic wait_edges(input int n, input int budget);
        int k;
        k = 0;
        while (edges < n && k < budget) begin
            cyc();
            k++;
        end
        chk("edges_reached", 32'(edges >= n), 32'd1);
    endtask

    // TX Fifo model: advance the head just after the edge on which the pop was taken.
    always @(posedge clock) begin
        if (pop_pend) begin
            pop_pend = 1'b0;
            #1;
            if (txq.size() > 0) void'(txq.pop_front());
            refresh_tx();
        end
    end

    // Mode-3 slave: presents its next bit on every leading SCLK edge.
    always @(sclk) begin
        if (!loop && !chipSelectN && sclk !== cpol && sidx < 32) begin
            miso_s = slave_word[31-sidx];
            sidx++;
        end
    end

    always @(negedge clock) begin
        if (txPop === 1'b1) begin
            pops++;
            pop_pend = 1'b1;
        end
        if (rxPush === 1'b1) begin
            pushes++;
            if (exp_q.size() > 0) chk("rxData", rxData, exp_q.pop_front());
            else chk("push_outstanding", 32'(exp_q.size()), 32'd1);
        end
        if (txPop === 1'b1 && rxPush === 1'b1) coinc++;
        if (busy === chipSelectN) busy_cs_bad++;
        if (chipSelectN === 1'b1 && cs_prev === 1'b0) cs_rises++;
        cs_prev = chipSelectN;
        if (sclk !== sclk_prev) begin
            edges++;
            if (last_tog >= 0) begin
                if (cyc_n - last_tog < hp_min) hp_min = cyc_n - last_tog;
                if (cyc_n - last_tog > hp_max) hp_max = cyc_n - last_tog;
            end
            last_tog = cyc_n;
            if (sclk !== cpol && mosi_n < 32) begin
                mosi_cap[mosi_n] = mosi;
                mosi_n++;
            end
        end
        sclk_prev = sclk;
        cyc_n++;
    end

    initial begin
        areset = 1'b0; enable = 1'b0; clockDivider = 8'd0;
        cpol = 1'b0; cpha = 1'b0; lsbFirst = 1'b0; rxFull = 1'b0; loop = 1'b1;
        refresh_tx();
        reset_stats();
        cyc(); cyc();
        chk("rst_sclk", 32'(sclk), 32'd0);
        chk("rst_mosi", 32'(mosi), 32'd0);
        chk("rst_cs", 32'(chipSelectN), 32'd1);
        chk("rst_txPop", 32'(txPop), 32'd0);
        chk("rst_rxPush", 32'(rxPush), 32'd0);
        chk("rst_rxData", rxData, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        areset = 1'b1;
        cyc(); cyc();

        // Mode 0, divider 0, MSB first, loopback
        reset_stats();
        queue_word(32'hA5A50F0F, 32'hA5A50F0F);
        enable = 1'b1;
        wait_pushes(1, 2000);
        wait_idle(200);
        enable = 1'b0;
        cyc();
        chk("m0_pops", 32'(pops), 32'd1);
        chk("m0_edges", 32'(edges), 32'd64);
        chk("m0_half_min", 32'(hp_min), 32'd1);
        chk("m0_half_max", 32'(hp_max), 32'd1);
        chk("m0_mosi_bits", mosi_cap, bitrev(32'hA5A50F0F));
        chk("m0_cs_high", 32'(chipSelectN), 32'd1);

        // Mode 3, divider 3, slave returns 12345678
        cpol = 1'b1; cpha = 1'b1; clockDivider = 8'd3; loop = 1'b0;
        slave_word = 32'h12345678; sidx = 0;
        cyc(); cyc(); cyc();
        reset_stats();
        chk("m3_sclk_idle", 32'(sclk), 32'd1);
        queue_word(32'hDEADBEEF, 32'h12345678);
        enable = 1'b1;
        wait_pushes(1, 2000);
        wait_idle(200);
        enable = 1'b0;
        cyc();
        chk("m3_edges", 32'(edges), 32'd64);
        chk("m3_half_min", 32'(hp_min), 32'd4);
        chk("m3_half_max", 32'(hp_max), 32'd4);
        chk("m3_mosi_bits", mosi_cap, bitrev(32'hDEADBEEF));
        chk("m3_sclk_end", 32'(sclk), 32'd1);

        // LSB first, mode 0, loopback
        cpol = 1'b0; cpha = 1'b0; clockDivider = 8'd0; lsbFirst = 1'b1; loop = 1'b1;
        cyc(); cyc(); cyc();
        reset_stats();
        queue_word(32'h00000001, 32'h00000001);
        enable = 1'b1;
        wait_pushes(1, 2000);
        wait_idle(200);
        enable = 1'b0;
        cyc();
        chk("lsb_mosi_bits", mosi_cap, 32'h00000001);
        chk("lsb_mosi_count", 32'(mosi_n), 32'd32);

        // Back-to-back: three preloaded words
        lsbFirst = 1'b0; clockDivider = 8'd1;
        cyc();
        reset_stats();
        queue_word(32'd186, 32'd186);
        queue_word(32'd217, 32'd217);
        queue_word(32'd248, 32'd248);
        enable = 1'b1;
        wait_pushes(3, 4000);
        wait_idle(200);
        enable = 1'b0;
        cyc();
        chk("b2b_pops", 32'(pops), 32'd3);
        chk("b2b_coincident", 32'(coinc), 32'd0);
        chk("b2b_cs_rises", 32'(cs_rises), 32'd1);
        chk("b2b_edges", 32'(edges), 32'd192);
        chk("b2b_cs_high", 32'(chipSelectN), 32'd1);
        chk("busy_tracks_cs", 32'(busy_cs_bad), 32'd0);

        // RX full stall
        clockDivider = 8'd0;
        reset_stats();
        rxFull = 1'b1;
        queue_word(32'h3C3CC3C3, 32'h3C3CC3C3);
        enable = 1'b1;
        repeat (20) cyc();
        chk("stall_pops", 32'(pops), 32'd0);
        chk("stall_cs", 32'(chipSelectN), 32'd1);
        chk("stall_busy", 32'(busy), 32'd0);
        rxFull = 1'b0;
        #1;
        chk("stall_release_pop", 32'(txPop), 32'd1);
        wait_pushes(1, 2000);
        wait_idle(200);
        enable = 1'b0;
        cyc();

        // Reset abort after 10 edges
        reset_stats();
        queue_word(32'hFFFFFFFF, 32'hFFFFFFFF);
        enable = 1'b1;
        wait_edges(10, 500);
        areset = 1'b0;
        #1;
        chk("abort_sclk", 32'(sclk), 32'd0);
        chk("abort_mosi", 32'(mosi), 32'd0);
        chk("abort_cs", 32'(chipSelectN), 32'd1);
        chk("abort_txPop", 32'(txPop), 32'd0);
        chk("abort_rxPush", 32'(rxPush), 32'd0);
        chk("abort_rxData", rxData, 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        exp_q.delete();
        txq.delete();
        refresh_tx();
        enable = 1'b0;
        cyc(); cyc();
        areset = 1'b1;
        repeat (100) cyc();
        chk("abort_no_push", 32'(pushes), 32'd0);
        chk("abort_pops", 32'(pops), 32'd1);

        // Enable dropped mid-frame
        reset_stats();
        queue_word(32'h0F0F1234, 32'h0F0F1234);
        enable = 1'b1;
        wait_edges(10, 500);
        enable = 1'b0;
        txq.push_back(32'h55555555);
        refresh_tx();
        wait_pushes(1, 2000);
        wait_idle(200);
        repeat (40) cyc();
        chk("endrop_pops", 32'(pops), 32'd1);
        chk("endrop_pushes", 32'(pushes), 32'd1);
        chk("endrop_cs", 32'(chipSelectN), 32'd1);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        txq.delete();
        refresh_tx();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/spi_shift_engine.md
Name: spi_shift_engine

Overview:
- SPI master serializer between the TX and RX Fifo instances.
- Takes words from the TX Fifo's read port (pop side) and shifts them out on MOSI while sampling MISO.
- Pushes each received word into the RX Fifo's write port.
- Handles SCLK generation, CPOL/CPHA modes, bit order, chip-select framing and back-to-back words.

Parameters:
DATA_BUS_SIZE, 32, word length in bits; one SPI frame = DATA_BUS_SIZE bits
CLOCK_DIV_WIDTH, 8, width of clockDivider

Ports:
clock  in  1  system clock
areset  in  1  asynchronous reset, active-low
enable  in  1  allows new words to start; a word in flight always completes
clockDivider  in  CLOCK_DIV_WIDTH  SCLK half-period = clockDivider+1 clocks
cpol  in  1  SCLK idle level
cpha  in  1  0: sample on leading edge; 1: sample on trailing edge
lsbFirst  in  1  1: LSB shifted first
txEmpty  in  1  TX Fifo empty
txData  in  DATA_BUS_SIZE  TX Fifo head word, valid while txEmpty=0
txPop  out  1  one-cycle pop strobe to TX Fifo
rxFull  in  1  RX Fifo full
rxPush  out  1  one-cycle push strobe to RX Fifo
rxData  out  DATA_BUS_SIZE  received word; held until the next push
sclk  out  1  SPI clock
mosi  out  1  SPI data out
miso  in  1  SPI data in, synchronous to clock (synchronizer is external)
chipSelectN  out  1  active-low chip select
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (areset=0, asynchronous):
  - sclk=0, mosi=0, chipSelectN=1, txPop=0, rxPush=0, rxData=0, busy=0.
  - State = IDLE; all counters cleared.
  - A word in flight is aborted: no push, no further pop.
- States: IDLE, LEAD, SHIFT, TRAIL.
- IDLE:
  - sclk = live cpol, chipSelectN=1.
  - Start condition, checked every cycle: enable && !txEmpty && !rxFull.
  - On start, in the same cycle: txPop=1, capture txData into the shift register, latch cpol/cpha/lsbFirst/clockDivider.
  - Next cycle: chipSelectN=0, go LEAD.
  - Latched config is used for the whole frame; input changes mid-frame are ignored.
- LEAD:
  - Lasts one half-period.
  - If cpha=0, mosi presents the first bit on entry.
  - Then go SHIFT.
- SHIFT:
  - Exactly 2*DATA_BUS_SIZE SCLK edges, one every half-period; sclk toggles on each.
  - cpha=0: sample miso on the leading (odd) edges; shift the next bit onto mosi on the trailing (even) edges.
  - cpha=1: drive the first bit on the first leading edge, shift on leading edges, sample on trailing edges.
  - Bit order per latched lsbFirst, for both TX and RX assembly.
  - sclk returns to cpol after the final edge.
- TRAIL:
  - Entered after the last edge; lasts one half-period.
  - First cycle of TRAIL: rxPush=1 and rxData = assembled word.
  - The push can never overflow: rxFull was 0 at frame start and this block is the RX Fifo's only writer.
  - At end of TRAIL, if the start condition is true: txPop=1, reload the shift register, chipSelectN stays 0, go LEAD (back-to-back, no CS gap).
  - Otherwise chipSelectN=1 and go IDLE.
  - IDLE holds CS high at least one half-period before a new start is honoured.
- enable dropped mid-frame: frame completes including push; no new frame starts.
- Stall: rxFull=1 or txEmpty=1 is only evaluated at frame boundaries. The engine waits in IDLE with CS high; no partial frames.
- Simultaneous events: txPop and rxPush never assert in the same cycle (push is in the first TRAIL cycle, pop in the last; with divider=0 TRAIL is still at least 2 cycles).
- Divider arithmetic: the half-period counter counts 0..clockDivider, so clockDivider=0 gives SCLK = clock/2. The edge counter is $clog2(2*DATA_BUS_SIZE)+1 bits wide and does not wrap.

Test Plan:
- Mode 0, clockDivider=0, MSB-first, txData=32'hA5A50F0F, miso looped to mosi:
  - exactly 1 txPop and 64 sclk edges, sclk period 2 clocks;
  - one rxPush with rxData=32'hA5A50F0F;
  - chipSelectN high again after TRAIL.
- Mode 3 (cpol=1, cpha=1), clockDivider=3, MISO driven from a model returning 32'h12345678:
  - sclk idles high, period 8 clocks, 32 periods;
  - rxData=32'h12345678.
- lsbFirst=1, txData=32'h00000001: first mosi bit is 1, remaining 31 bits are 0; loopback returns 32'h00000001.
- Back-to-back, three words preloaded (186, 217, 248):
  - chipSelectN stays low across all three frames;
  - 3 pops, 3 pushes in order, pops and pushes never coincident;
  - CS rises after frame 3; busy falls with it.
- rxFull=1 with txEmpty=0:
  - no txPop, CS stays high, busy=0;
  - after rxFull is released, txPop within 1 cycle.
- Control aborts:
  - areset=0 after 10 edges: all outputs at reset values immediately, no rxPush.
  - enable=0 after 10 edges: frame completes with 1 push, then IDLE.
